// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: memory/write-back FSM states, instruction field
// positions and the compare-opcode set also used by the ALU stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWb
    } memwb_state_e;

    localparam int unsigned LsClassHi = 27;
    localparam int unsigned LsClassLo = 26;
    localparam int unsigned LBit      = 20;
    localparam int unsigned OpcodeHi  = 24;
    localparam int unsigned OpcodeLo  = 21;
    localparam int unsigned RdHi      = 15;
    localparam int unsigned RdLo      = 12;

    localparam logic [1:0] LsClass = 2'b01;

    localparam logic [3:0] OpTst = 4'b1000;
    localparam logic [3:0] OpTeq = 4'b1001;
    localparam logic [3:0] OpCmp = 4'b1010;
    localparam logic [3:0] OpCmn = 4'b1011;

    // Compare-class ops only update flags and never write a register.
    function automatic logic is_compare_op(input logic [3:0] op);
        return (op == OpTst) || (op == OpTeq) || (op == OpCmp) || (op == OpCmn);
    endfunction

endpackage

// File: rtl/memwb_watchdog.sv
// Request watchdog: counts consecutive un-acked REQ cycles, raises a one-cycle
// abort on the last allowed cycle and keeps a sticky error flag until reset.
module memwb_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ack,
    output logic timeout,
    output logic err
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // An ack on the final cycle still wins over the abort.
    assign timeout = active && !ack && (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = '0;
        err_d = err_q | timeout;
        if (active && !ack && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: register write-back or a req/ack data memory
// transaction with upstream stall. Optional request timeout under MEMWB_TIMEOUT_EN.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [31:0]       instruction_in,
    input  logic              condition_in,
    input  logic              LS_in,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              wb_en,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              mem_err
);

    memwb_state_e      state_q, state_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              wb_en_q, wb_en_d;
    logic [3:0]        wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              req_timeout;

    logic [3:0] opcode;
    logic [3:0] rd;

    assign opcode = instruction_in[OpcodeHi:OpcodeLo];
    assign rd     = instruction_in[RdHi:RdLo];

    // Class decode is done upstream and arrives as LS_in; remaining fields are unused here.
    logic unused_instr;
    assign unused_instr = ^{instruction_in[31:28], instruction_in[25],
                            instruction_in[19:16], instruction_in[11:0]}
                          ^ (instruction_in[LsClassHi:LsClassLo] == LsClass);

`ifdef MEMWB_TIMEOUT_EN
    logic in_req;
    assign in_req = (state_q == StReq);

    memwb_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .active (in_req),
        .ack    (mem_ack),
        .timeout(req_timeout),
        .err    (mem_err)
    );
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
    assign req_timeout = 1'b0;
    assign mem_err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        wb_en_d     = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;

        unique case (state_q)
            StIdle: begin
                if (condition_in) begin
                    if (LS_in) begin
                        mem_addr_d  = alu_out;
                        mem_wdata_d = store_data;
                        mem_we_d    = !instruction_in[LBit];
                        wb_addr_d   = rd;
                        state_d     = StReq;
                    end else if (!is_compare_op(opcode)) begin
                        wb_en_d   = 1'b1;
                        wb_addr_d = rd;
                        wb_data_d = alu_out;
                    end
                end
            end
            StReq: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        wb_data_d = mem_rdata;
                        wb_en_d   = 1'b1;
                        state_d   = StWb;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (req_timeout) begin
                    state_d = StIdle;
                end
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            wb_en_q     <= wb_en_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign mem_req   = (state_q == StReq);
    assign stall     = (state_q != StIdle);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_en     = wb_en_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cases plus randomized transactions checked
// against a transaction-level expectation model. Timeout case under MEMWB_TIMEOUT_EN.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] alu_out = '0;
    logic [31:0] instruction_in = '0;
    logic        condition_in = 1'b0;
    logic        LS_in = 1'b0;
    logic [15:0] store_data = '0;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        stall;
    logic        mem_err;

    int n_assert = 0;
    int n_fail   = 0;
    bit mem_err_exp = 1'b0;

    mem_wb_stage #(
        .DATA_W     (16),
        .TIMEOUT_CYC(15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_out       (alu_out),
        .instruction_in(instruction_in),
        .condition_in  (condition_in),
        .LS_in         (LS_in),
        .store_data    (store_data),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .stall         (stall),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_instr(input bit ls, input bit l, input logic [3:0] op,
                                             input logic [3:0] rd);
        logic [31:0] r;
        r = $urandom;
        r[31:28] = 4'hE;
        r[27:26] = ls ? 2'b01 : 2'b00;
        r[24:21] = op;
        r[20]    = l;
        r[15:12] = rd;
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_wb_en"}, 32'(wb_en), 32'd0);
        chk({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
        chk({tag, "_wb_data"}, 32'(wb_data), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_mem_err"}, 32'(mem_err), 32'd0);
    endtask

    task automatic idle_check();
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_mem_req", 32'(mem_req), 32'd0);
        chk("idle_mem_err", 32'(mem_err), 32'(mem_err_exp));
    endtask

    // Non-memory instruction: writes back next cycle unless bubble or compare op.
    task automatic do_dp(input bit cond, input logic [3:0] op, input logic [3:0] rd,
                         input logic [15:0] val);
        bit exp_wb;
        idle_check();
        instruction_in = mk_instr(1'b0, 1'($urandom), op, rd);
        condition_in   = cond;
        LS_in          = cond ? 1'b0 : 1'($urandom);
        alu_out        = val;
        store_data     = 16'($urandom);
        mem_rdata      = 16'($urandom);
        mem_ack        = 1'($urandom);
        exp_wb = cond && !(op >= 4'd8 && op <= 4'd11);
        step();
        condition_in = 1'b0;
        LS_in        = 1'b0;
        mem_ack      = 1'b0;
        chk("dp_wb_en", 32'(wb_en), 32'(exp_wb));
        chk("dp_stall", 32'(stall), 32'd0);
        chk("dp_mem_req", 32'(mem_req), 32'd0);
        if (exp_wb) begin
            chk("dp_wb_addr", 32'(wb_addr), 32'(rd));
            chk("dp_wb_data", 32'(wb_data), 32'(val));
        end
    endtask

    // Load/store with `waits` cycles of REQ before the ack cycle.
    task automatic do_mem(input bit load, input logic [3:0] rd, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rdata, input int waits);
        idle_check();
        instruction_in = mk_instr(1'b1, load, 4'($urandom), rd);
        condition_in   = 1'b1;
        LS_in          = 1'b1;
        alu_out        = addr;
        store_data     = wdata;
        mem_ack        = 1'($urandom);
        step();
        condition_in = 1'b0;
        LS_in        = 1'b0;
        alu_out      = 16'($urandom);
        store_data   = 16'($urandom);
        for (int i = 0; i <= waits; i++) begin
            chk("req_mem_req", 32'(mem_req), 32'd1);
            chk("req_mem_we", 32'(mem_we), 32'(!load));
            chk("req_mem_addr", 32'(mem_addr), 32'(addr));
            if (!load) chk("req_mem_wdata", 32'(mem_wdata), 32'(wdata));
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_wb_en", 32'(wb_en), 32'd0);
            mem_ack   = (i == waits);
            mem_rdata = (i == waits) ? rdata : 16'($urandom);
            step();
        end
        mem_ack = 1'b0;
        if (load) begin
            chk("ld_wb_en", 32'(wb_en), 32'd1);
            chk("ld_wb_addr", 32'(wb_addr), 32'(rd));
            chk("ld_wb_data", 32'(wb_data), 32'(rdata));
            chk("ld_wb_stall", 32'(stall), 32'd1);
            chk("ld_wb_mem_req", 32'(mem_req), 32'd0);
            step();
            chk("ld_after_wb_en", 32'(wb_en), 32'd0);
        end else begin
            chk("st_after_mem_req", 32'(mem_req), 32'd0);
            chk("st_after_stall", 32'(stall), 32'd0);
            chk("st_after_wb_en", 32'(wb_en), 32'd0);
        end
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        step();

        // ADD R3
        do_dp(1'b1, 4'b0100, 4'd3, 16'h1234);
        // CMP: no write-back over three cycles
        do_dp(1'b1, 4'b1010, 4'd6, 16'h5555);
        for (int i = 0; i < 2; i++) begin
            chk("cmp_wb_en_hold", 32'(wb_en), 32'd0);
            step();
        end
        // Load R5 from 0x0040, two wait cycles
        do_mem(1'b1, 4'd5, 16'h0040, 16'h0000, 16'hBEEF, 2);
        // Store 0x00AA to 0x0010, immediate ack
        do_mem(1'b0, 4'd2, 16'h0010, 16'h00AA, 16'h0000, 0);
        // R15 written like any other register; compare-class boundaries
        do_dp(1'b1, 4'b1111, 4'd15, 16'hFFFF);
        do_dp(1'b1, 4'b0111, 4'd1, 16'h0001);
        do_dp(1'b1, 4'b1000, 4'd1, 16'h0002);
        do_dp(1'b1, 4'b1011, 4'd1, 16'h0003);
        do_dp(1'b1, 4'b1100, 4'd1, 16'h0004);
        do_dp(1'b0, 4'b0100, 4'd9, 16'h0005);

        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind < 2) begin
                do_dp(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 16'($urandom));
            end else begin
                do_mem(kind == 2, 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                       $urandom_range(0, 3));
            end
        end

`ifdef MEMWB_TIMEOUT_EN
        idle_check();
        instruction_in = mk_instr(1'b1, 1'b1, 4'd0, 4'd4);
        condition_in   = 1'b1;
        LS_in          = 1'b1;
        alu_out        = 16'h0100;
        step();
        condition_in = 1'b0;
        LS_in        = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("to_mem_req", 32'(mem_req), 32'd1);
            chk("to_mem_err_pre", 32'(mem_err), 32'd0);
            chk("to_wb_en_pre", 32'(wb_en), 32'd0);
            step();
        end
        mem_err_exp = 1'b1;
        chk("to_mem_req_drop", 32'(mem_req), 32'd0);
        chk("to_stall_drop", 32'(stall), 32'd0);
        chk("to_mem_err", 32'(mem_err), 32'd1);
        chk("to_wb_en", 32'(wb_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_mem_err_sticky", 32'(mem_err), 32'd1);
            chk("to_wb_en_after", 32'(wb_en), 32'd0);
        end
        do_dp(1'b1, 4'b0000, 4'd8, 16'h0A0A);
`endif

        // Reset mid-REQ
        idle_check();
        instruction_in = mk_instr(1'b1, 1'b1, 4'd0, 4'd7);
        condition_in   = 1'b1;
        LS_in          = 1'b1;
        alu_out        = 16'h0080;
        step();
        condition_in = 1'b0;
        LS_in        = 1'b0;
        chk("rst_pre_mem_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        mem_err_exp = 1'b0;
        check_all_zero("midreq_reset");
        @(posedge clk);
        #3 reset = 1'b1;
        do_dp(1'b1, 4'b0100, 4'd7, 16'h5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
